// File: rtl/wb_axi_write_ctrl.sv
// rtl/wb_axi_write_ctrl.sv - write-buffer drain controller: one 16-byte line as a 4-beat AXI INCR burst
// Latches the head entry, issues AW then four W beats, waits for B, and retires the entry with a pop pulse.
module wb_axi_write_ctrl #(
  parameter logic [3:0] AWID_VAL = 4'd1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wb_valid_i,
  input  logic [31:0]  wb_addr_i,
  input  logic [127:0] wb_data_i,
  input  logic         wb_hold_i,
  output logic         wb_pop_o,
  output logic         busy_o,
  output logic         err_o,
  output logic [3:0]   awid,
  output logic [31:0]  awaddr,
  output logic [7:0]   awlen,
  output logic [2:0]   awsize,
  output logic [1:0]   awburst,
  output logic         awvalid,
  input  logic         awready,
  output logic [31:0]  wdata,
  output logic [3:0]   wstrb,
  output logic         wlast,
  output logic         wvalid,
  input  logic         wready,
  input  logic [3:0]   bid,
  input  logic [1:0]   bresp,
  input  logic         bvalid,
  output logic         bready
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    S_RESP = 3'd3,
    S_POP  = 3'd4
  } state_t;

  state_t       state_q, state_d;
  logic [31:0]  addr_q, addr_d;
  logic [127:0] data_q, data_d;
  logic [1:0]   beat_q, beat_d;
  logic         err_q, err_d;

  // The ID is not checked and the low address bits are dropped by line alignment.
  logic unused_bits;
  assign unused_bits = ^{bid, wb_addr_i[3:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    beat_d  = beat_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (wb_valid_i) begin
          addr_d  = {wb_addr_i[31:4], 4'b0000};
          data_d  = wb_data_i;
          beat_d  = 2'd0;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (awready) state_d = S_DATA;
      end
      S_DATA: begin
        if (wready) begin
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'd3) state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (bvalid) begin
          if (bresp != 2'b00) err_d = 1'b1;
          // A merge into the head during the burst means the line must be re-sent whole.
          state_d = wb_hold_i ? S_IDLE : S_POP;
        end
      end
      S_POP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    awid     = AWID_VAL;
    awlen    = 8'd3;
    awsize   = 3'b010;
    awburst  = 2'b01;
    awaddr   = addr_q;
    awvalid  = (state_q == S_ADDR);
    wvalid   = (state_q == S_DATA);
    wstrb    = 4'h0;
    wdata    = '0;
    wlast    = 1'b0;
    if (state_q == S_DATA) begin
      wstrb = 4'hF;
      wdata = data_q[{beat_q, 5'b00000} +: 32];
      wlast = (beat_q == 2'd3);
    end
    bready   = (state_q == S_RESP);
    wb_pop_o = (state_q == S_POP);
    busy_o   = (state_q != S_IDLE);
    err_o    = err_q;
  end

endmodule
